// File: rtl/selsplit_issue_ctrl_if.sv
// Upstream valid/ready word port of the SelSplit_2 issue controller.
// The master side offers destination-tagged words and the slave side accepts them.
interface selsplit_issue_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_dest;

    modport master (output s_valid, s_data, s_dest, input s_ready);
    modport slave  (input s_valid, s_data, s_dest, output s_ready);
endinterface

// File: rtl/selsplit_issue_ctrl.sv
// Issue controller for a SelSplit_2 stage with per-branch credits and a synchronized free handshake.
// Defining SELSPLIT_ISSUE_CTRL_TIMEOUT_EN adds a WAIT_FREE watchdog with a sticky error state.
module selsplit_issue_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CREDIT_MAX = 4,
    parameter int DRIVE_HOLD = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    selsplit_issue_ctrl_if.slave  s_if,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid0,
    output logic                  o_valid1,
    output logic                  o_drive,
    input  logic                  i_free,
    input  logic                  i_done0,
    input  logic                  i_done1,
    output logic [3:0]            o_credit0,
    output logic [3:0]            o_credit1,
    input  logic                  i_clr_err,
    output logic                  o_err
);
    localparam int                HOLD_W      = (DRIVE_HOLD > 1) ? $clog2(DRIVE_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(DRIVE_HOLD - 1);
    localparam logic [3:0]        CREDIT_FULL = 4'(CREDIT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DRIVE,
        WAIT_FREE
`ifdef SELSPLIT_ISSUE_CTRL_TIMEOUT_EN
        , ERR
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            valid_q, valid_d;
    logic                  dest_q, dest_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [1:0][3:0]       credit_q, credit_d;
    logic [2:0]            free_sync_q;
    logic [1:0]            done;
    logic                  free_evt;
    logic                  issue;

`ifdef SELSPLIT_ISSUE_CTRL_TIMEOUT_EN
    localparam int                 TIMER_W    = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    logic [TIMER_W-1:0] timer_q, timer_d;
`else
    logic unused_cfg;
    assign unused_cfg = i_clr_err ^ (TIMEOUT > 0);
`endif

    assign done     = {i_done1, i_done0};
    // Bits [1:0] are the two-flop synchronizer; bit 2 only delays bit 1 for edge detection.
    assign free_evt = free_sync_q[1] & ~free_sync_q[2];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        dest_d  = dest_q;
        hold_d  = hold_q;
        issue   = 1'b0;
`ifdef SELSPLIT_ISSUE_CTRL_TIMEOUT_EN
        timer_d = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_if.s_valid) begin
                    data_d  = s_if.s_data;
                    dest_d  = s_if.s_dest;
                    valid_d = s_if.s_dest ? 2'b10 : 2'b01;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // A credit returning this very cycle is usable immediately.
                if (credit_q[dest_q] != 4'd0 || done[dest_q]) begin
                    issue   = 1'b1;
                    hold_d  = '0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = WAIT_FREE;
`ifdef SELSPLIT_ISSUE_CTRL_TIMEOUT_EN
                    timer_d = '0;
`endif
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            WAIT_FREE: begin
                if (free_evt) begin
                    valid_d = 2'b00;
                    state_d = IDLE;
                end
`ifdef SELSPLIT_ISSUE_CTRL_TIMEOUT_EN
                else if (timer_q == TIMER_LAST) begin
                    valid_d = 2'b00;
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
`endif
            end
`ifdef SELSPLIT_ISSUE_CTRL_TIMEOUT_EN
            ERR: begin
                if (i_clr_err) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        credit_d = credit_q;
        for (int b = 0; b < 2; b++) begin
            if (issue && dest_q == 1'(b)) begin
                if (!done[b]) credit_d[b] = credit_q[b] - 4'd1;
            end else if (done[b] && credit_q[b] != CREDIT_FULL) begin
                credit_d[b] = credit_q[b] + 4'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            valid_q     <= 2'b00;
            dest_q      <= 1'b0;
            hold_q      <= '0;
            credit_q    <= {CREDIT_FULL, CREDIT_FULL};
            free_sync_q <= 3'b000;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            dest_q      <= dest_d;
            hold_q      <= hold_d;
            credit_q    <= credit_d;
            free_sync_q <= {free_sync_q[1:0], i_free};
        end
    end

`ifdef SELSPLIT_ISSUE_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) timer_q <= '0;
        else      timer_q <= timer_d;
    end

    assign o_err = (state_q == ERR);
`else
    assign o_err = 1'b0;
`endif

    assign s_if.s_ready = rst & (state_q == IDLE);
    assign o_data       = data_q;
    assign o_valid0     = valid_q[0];
    assign o_valid1     = valid_q[1];
    assign o_drive      = (state_q == DRIVE);
    assign o_credit0    = credit_q[0];
    assign o_credit1    = credit_q[1];
endmodule

// File: doc/selsplit_issue_ctrl.md
# selsplit_issue_ctrl

Clocked issue controller that sequences a 2-way conditional split stage (SelSplit_2 family). It accepts destination-tagged words over a valid/ready port and presents data plus a one-hot branch select to the split. It then fires the split's drive strobe and waits for the split's asynchronous free event before issuing the next word. Per-branch credit counters keep it from overrunning either downstream branch, and an optional watchdog flags a split that never returns free.

## Interface
- DATA_WIDTH, 32, width of the data word
- CREDIT_MAX, 4, per-branch outstanding-token limit (1..15)
- DRIVE_HOLD, 2, cycles o_drive is held high (>=1)
- TIMEOUT, 255, WAIT_FREE cycles before error (>=1; used only with the watchdog)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- s_valid  in  1  upstream word valid
- s_ready  out  1  upstream ready
- s_data  in  DATA_WIDTH  upstream word
- s_dest  in  1  destination branch (0/1)
- o_data  out  DATA_WIDTH  word to split i_data
- o_valid0 / o_valid1  out  1 each  one-hot branch select to split valid0/valid1
- o_drive  out  1  drive strobe to split i_drive
- i_free  in  1  split o_free; asynchronous to clk
- i_done0 / i_done1  in  1 each  one-cycle credit-return pulses from branch 0/1 consumers, synchronous to clk
- o_credit0 / o_credit1  out  4 each  credits currently available per branch
- i_clr_err  in  1  clears error state
- o_err  out  1  sticky watchdog error

## Operation
- FSM states: IDLE, SETUP, DRIVE, WAIT_FREE, ERR (ERR present only with the macro).
- IDLE: s_ready=1. When s_valid is high, register s_data into o_data and set o_valid[s_dest]=1 (other valid 0), then go to SETUP.
- SETUP: s_ready=0. Outputs are stable. If credit[dest]>0, go to DRIVE and decrement credit[dest]. Otherwise stay in SETUP; there is no timeout while stalled on credit.
- DRIVE: o_drive=1 for exactly DRIVE_HOLD cycles, then go to WAIT_FREE.
- WAIT_FREE: wait for a free event. On the event, clear o_valid0/1 and go to IDLE. o_data holds its last value.
- i_free passes through a 2-flop synchronizer. The free event is the rising edge of the synchronized signal (third flop for edge detect).
- A free event outside WAIT_FREE is ignored.
- Credits:
  - Each counter starts at CREDIT_MAX.
  - An issue decrements the counter; an i_doneN pulse increments it.
  - Issue and done on the same branch in the same cycle leave the count unchanged.
  - A done pulse at CREDIT_MAX saturates and is ignored.
  - Counters are 4 bits; unused upper bits read 0.
- Reset (asynchronous, any state):
  - state=IDLE, s_ready=0 while rst is low, then 1 in IDLE.
  - o_data=0, o_valid0=o_valid1=0, o_drive=0, o_err=0.
  - credits=CREDIT_MAX; synchronizer flops and timers cleared.
- Reset asserted mid-DRIVE drops o_drive immediately. The in-flight word is lost, and its credit is restored by the reload.

## Timing
- Word accepted at edge T (s_valid & s_ready):
  - o_data/o_valid valid after T.
  - DRIVE entered at T+1 if credit is available.
  - o_drive high from T+1 through T+DRIVE_HOLD.
- Data and valid are stable at least one cycle before o_drive rises. They hold until the free event is detected.
- Free latency: i_free rising before edge F is detected at edge F+2. The FSM is back in IDLE, with s_ready=1, after F+2.
- Minimum issue period with immediate free: 1 + DRIVE_HOLD + 3 cycles.
- o_credit reflects the decrement in the cycle after SETUP→DRIVE.

## Configuration
- SELSPLIT_ISSUE_CTRL_TIMEOUT_EN defined:
  - An 8-bit-or-wider timer counts WAIT_FREE cycles.
  - After TIMEOUT cycles with no free event, go to ERR: o_err=1, o_valid cleared, s_ready=0.
  - i_clr_err high in ERR returns the FSM to IDLE and clears o_err next cycle. Credits are unchanged; the lost token's credit stays consumed.
- Not defined: no timer and no ERR state. WAIT_FREE waits indefinitely, o_err is tied 0, and i_clr_err is ignored.

## Test plan
- Reset then single word: s_data=0xA5A5_0001, s_dest=1 at T.
  - Response: o_valid1=1 after T, o_drive high for 2 cycles from T+1, o_credit1 drops 4→3.
  - Pulse i_free: o_valid1=0 and s_ready=1 three edges later.
- Credit exhaustion: issue 4 words to branch 0 with no i_done0.
  - Response: 5th word stalls in SETUP with o_drive=0.
  - Pulse i_done0 once: DRIVE on the next edge, o_credit0 stays 0.
- Simultaneous issue and done on branch 0 at credit 2: credit remains 2. i_done1 at credit 4 leaves credit1=4.
- Spurious free: toggle i_free in IDLE. No state change and no credit change.
- With the macro, TIMEOUT=8 and no i_free:
  - Response: o_err=1 after 8 WAIT_FREE cycles, s_ready=0.
  - Pulse i_clr_err: IDLE and o_err=0.
  - Without the macro: o_err stays 0 for 1000 cycles.
- Assert rst during DRIVE: o_drive, o_valid and o_data go to 0 immediately. Credits read 4/4 after release.
